// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Converts a simple valid/ready command stream into single APB transfers and
// returns one valid/ready response per command. One transfer is in flight at
// a time. An optional ACCESS-phase timeout aborts transfers whose slave never
// raises PREADY.
//
// Parameters
//   ADDR_W   : PADDR / cmd_addr width
//   DATA_W   : PWDATA / PRDATA / cmd / rsp data width
//   TIMEOUT  : maximum ACCESS-phase wait cycles, 0 disables the timeout
//
// Ports
//   PCLK, PRESET          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only while idle)
//   cmd_write/addr/wdata  : command payload
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : read data (0 for writes and timeouts)
//   rsp_err, rsp_timeout  : PSLVERR-or-timeout flag, timeout flag
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : APB master outputs
//   PRDATA, PREADY, PSLVERR              : APB slave responses
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Wide enough to hold TIMEOUT itself; at least one bit so the disabled
  // (TIMEOUT = 0) build still has a legal vector.
  localparam int              CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Decoded directly from the state register, so it is glitch-free and a
  // response handshake can never be followed by acceptance in the same cycle.
  assign cmd_ready = (state == IDLE);

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values; the reset branch is sampled on the clock
  // edge (synchronous), so PRESET never reaches the flops asynchronously.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end

        ACCESS: begin
          // PREADY is tested first so a completing slave beats a timeout that
          // would fire on the same edge.
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else if (TIMEOUT != 0 && wait_cnt == TO_VAL) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt != CNT_MAX) begin
            // Saturates instead of wrapping; only matters when the timeout is
            // disabled and the slave stalls indefinitely.
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
